// File: rtl/math_result_display.sv
// math_result_display - latches one add/sub result and scans it onto a 4-digit common-anode display
module math_result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] aplusb,
  input  logic [3:0] aminusb,
  input  logic       sel,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       valid
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ONE   = 7'b1111001;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          loadQ;
  logic [3:0]    capA, capB, capSum, capDiff;
  logic          capSel;
  logic [3:0]    nextAn;
  logic [6:0]    nextSeg;
  logic          nextDp;
  logic [3:0]    magnitude;
  logic          aLtB;
  logic          carry;

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: hexSeg = 7'b1000000;
      4'h1: hexSeg = 7'b1111001;
      4'h2: hexSeg = 7'b0100100;
      4'h3: hexSeg = 7'b0110000;
      4'h4: hexSeg = 7'b0011001;
      4'h5: hexSeg = 7'b0010010;
      4'h6: hexSeg = 7'b0000010;
      4'h7: hexSeg = 7'b1111000;
      4'h8: hexSeg = 7'b0000000;
      4'h9: hexSeg = 7'b0010000;
      4'hA: hexSeg = 7'b0001000;
      4'hB: hexSeg = 7'b0000011;
      4'hC: hexSeg = 7'b1000110;
      4'hD: hexSeg = 7'b0100001;
      4'hE: hexSeg = 7'b0000110;
      default: hexSeg = 7'b0001110;
    endcase
  endfunction

  // Carry and sign are recovered from the captured nibbles, not recomputed from scratch
  assign magnitude = ~capDiff + 4'd1;
  assign aLtB      = capA < capB;
  assign carry     = capSum < capA;

  always_comb begin
    nextAn  = ~(4'b0001 << idx);
    nextSeg = SEG_DASH;
    nextDp  = 1'b1;
    if (valid) begin
      case (idx)
        2'd3: nextSeg = hexSeg(capA);
        2'd2: begin
          nextSeg = hexSeg(capB);
          nextDp  = 1'b0;
        end
        2'd1: begin
          if (capSel) nextSeg = aLtB ? SEG_DASH : SEG_BLANK;
          else        nextSeg = carry ? SEG_ONE : SEG_BLANK;
        end
        default: begin
          if (!capSel)   nextSeg = hexSeg(capSum);
          else if (aLtB) nextSeg = hexSeg(magnitude);
          else           nextSeg = hexSeg(capDiff);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= 2'd0;
      loadQ   <= 1'b0;
      capA    <= 4'd0;
      capB    <= 4'd0;
      capSum  <= 4'd0;
      capDiff <= 4'd0;
      capSel  <= 1'b0;
      valid   <= 1'b0;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      loadQ <= load;
      if (load && !loadQ) begin
        capA    <= a;
        capB    <= b;
        capSum  <= aplusb;
        capDiff <= aminusb;
        capSel  <= sel;
        valid   <= 1'b1;
      end
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      an  <= nextAn;
      seg <= nextSeg;
      dp  <= nextDp;
    end
  end

endmodule
